dregs_seq: RTL and testbench
============================

# dregs_seq

Per-PE sequencer that drives the delay-register bank of the folded-FIR (FoFIR) datapath from the controller side. For each input sample it walks the taps, presents the tap index to the bank's read mux, writes each PAMAC result back into its tap register after a fixed PAMAC latency, then rotates the ring one position. It also issues bank-wide clears. It sits between the PE control FSM (start/clear/done) and the bank's per-tap enable, clear, input-select and tap-select controls.

## Interface
- nb_taps, 5, number of taps/registers in the bank (legal: 5, 7, 11)
- width_current_tap, nb_taps > 8 ? 4 : 3, width of tap index
- lat_pamac, 2, cycles from tap read (rd_valid) to result valid at bank input; legal range 1..4
- clk  input  1  sole clock, rising edge
- rst  input  1  reset; synchronous and active-high (one clock, polarity/synchronicity fixed)
- start  input  1  begin one sample sweep; sampled only in IDLE
- clr_req  input  1  clear all tap registers; sampled only in IDLE
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at end of a sweep
- rd_valid  output  1  tap read issued this cycle (PAMAC operand valid)
- current_tap_DRegs  output  width_current_tap  tap index to bank read mux
- DRegs_en  output  nb_taps  per-tap load enable
- DRegs_clr  output  nb_taps  per-tap synchronous clear
- DRegs_in_sel  output  nb_taps  per-tap input select: 0 = left neighbour (ring), 1 = PAMAC result

## Operation
- States: IDLE, CLEAR, ISSUE, DRAIN, ROTATE, DONE.
- IDLE: all outputs 0. If clr_req=1 -> CLEAR (clr_req wins over a simultaneous start; start is dropped). Else if start=1 -> ISSUE with tap counter 0. start/clr_req in any other state are ignored, not queued.
- CLEAR (1 cycle): DRegs_clr = all ones, DRegs_en = 0 -> IDLE. No done pulse.
- ISSUE (nb_taps cycles): rd_valid=1, current_tap_DRegs = counter, counter 0..nb_taps-1; after the last tap -> DRAIN.
- Write-back pipeline: lat_pamac-deep shift register of {valid, tap}. Entered each ISSUE cycle. When the output stage is valid for tap t: DRegs_en[t]=1, DRegs_in_sel[t]=1; all other bits 0.
- DRAIN: waits until the pipeline is empty (the last write is in the current cycle), then -> ROTATE.
- ROTATE (1 cycle): DRegs_en = all ones, DRegs_in_sel = all zeros (bank does D[i] <= D[i-1], D[0] <= D[nb_taps-1]) -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- Invariant: for every bit i, DRegs_en[i] & DRegs_clr[i] = 0 in every cycle. The bank drives X on that combination.
- Outside ISSUE: current_tap_DRegs = 0 and rd_valid = 0.
- DRegs_in_sel is 0 on every bit whose DRegs_en is 0.

## Timing
- All outputs are registered or decoded from registered state. After rst they are all 0, state is IDLE, and the pipeline is flushed.
- Cycle numbering: start sampled high at edge of cycle 0. Then:
  - ISSUE is cycles 1..nb_taps, tap k read in cycle k+1.
  - Write of tap k occurs in cycle k+1+lat_pamac.
  - ROTATE occurs in cycle nb_taps+lat_pamac+1.
  - done occurs in cycle nb_taps+lat_pamac+2.
  - Next start is accepted in cycle nb_taps+lat_pamac+3.
- Sweep length from start to done: nb_taps+lat_pamac+2 cycles.
- Writes never overlap ROTATE. DRAIN lasts lat_pamac cycles when lat_pamac ≥ 1.
- clr_req sampled in cycle 0: CLEAR in cycle 1, busy high in cycle 1 only, IDLE in cycle 2.
- rst asserted mid-sweep: on the next edge, state goes to IDLE and all outputs and pipeline go to 0; no done pulse and no pending write is issued. Bank contents are left to the bank's own reset.

## Test plan
- Reset: hold rst for 3 cycles mid-ISSUE -> next cycle all outputs 0 and busy=0; no DRegs_en bit rises afterward without a new start.
- Basic sweep, nb_taps=5, lat_pamac=2, start in cycle 0:
  - rd_valid in cycles 1–5 with current_tap_DRegs 0,1,2,3,4.
  - DRegs_en = DRegs_in_sel = 00001, 00010, 00100, 01000, 10000 in cycles 3–7.
  - Cycle 8: DRegs_en=11111, DRegs_in_sel=00000.
  - Cycle 9: done=1.
  - busy high in cycles 1–9.
- Clear priority: start=1 and clr_req=1 in the same IDLE cycle -> one cycle DRegs_clr=11111, DRegs_en=00000, then IDLE; no rd_valid, no done.
- Ignored requests: pulse start and clr_req during cycles 2–8 of a sweep -> waveform identical to the basic sweep; IDLE in cycle 10 with no second sweep.
- Parameter corners: nb_taps=11, lat_pamac=4 -> taps 0–10 in cycles 1–11, writes in cycles 5–15, ROTATE in cycle 16 with en=all ones, done in cycle 17. nb_taps=7, lat_pamac=1 -> done in cycle 10.
- Back-to-back sweeps with a scoreboard: a bank model plus a PAMAC model (result = read value + 1) over 3 sweeps. Check that the final register contents match the golden model and that en&clr is never set on the same bit.

Source files
------------

// File: rtl/dregs_seq.sv
// Delay-register bank sequencer for one FoFIR PE: walks the taps, writes the
// PAMAC results back after lat_pamac cycles, rotates the ring and clears the bank.

module dregs_seq_tap #(
  parameter int W   = 3,
  parameter int IDX = 0
) (
  input  logic         wr_vld,
  input  logic [W-1:0] wr_tap,
  input  logic         rotate,
  input  logic         clear,
  output logic         en,
  output logic         clr,
  output logic         in_sel
);
  logic hit;

  // A write-back and a rotate are never active in the same cycle.
  assign hit    = wr_vld && (wr_tap == W'(IDX));
  assign en     = hit | rotate;
  assign in_sel = hit;
  assign clr    = clear;
endmodule

module dregs_seq #(
  parameter int nb_taps           = 5,
  parameter int width_current_tap = (nb_taps > 8) ? 4 : 3,
  parameter int lat_pamac         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clr_req,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_valid,
  output logic [width_current_tap-1:0] current_tap_DRegs,
  output logic [nb_taps-1:0]           DRegs_en,
  output logic [nb_taps-1:0]           DRegs_clr,
  output logic [nb_taps-1:0]           DRegs_in_sel
);
  localparam int W = width_current_tap;
  localparam logic [W-1:0] LAST_TAP = W'(nb_taps - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, ROTATE, DONE} state_t;

  state_t                     state;
  // Stage 0 is the read being issued this cycle; stage lat_pamac is the write-back.
  logic [lat_pamac:0]         vld_pipe;
  logic [lat_pamac:0][W-1:0]  tap_pipe;
  logic                       is_rot;
  logic                       is_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vld_pipe <= '0;
      tap_pipe <= '0;
    end else begin
      for (int i = 1; i <= lat_pamac; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tap_pipe[i] <= tap_pipe[i-1];
      end
      case (state)
        IDLE: begin
          if (clr_req) state <= CLEAR;
          else if (start) begin
            state       <= ISSUE;
            vld_pipe[0] <= 1'b1;
            tap_pipe[0] <= '0;
          end
        end
        CLEAR: state <= IDLE;
        ISSUE: begin
          if (tap_pipe[0] == LAST_TAP) begin
            state       <= DRAIN;
            vld_pipe[0] <= 1'b0;
            tap_pipe[0] <= '0;
          end else begin
            tap_pipe[0] <= tap_pipe[0] + W'(1);
          end
        end
        // Leave once only the final write-back remains in flight.
        DRAIN:   if (!(|vld_pipe[lat_pamac-1:0])) state <= ROTATE;
        ROTATE:  state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy              = (state != IDLE);
  assign done              = (state == DONE);
  assign rd_valid          = vld_pipe[0];
  assign current_tap_DRegs = tap_pipe[0];
  assign is_rot            = (state == ROTATE);
  assign is_clr            = (state == CLEAR);

  for (genvar g = 0; g < nb_taps; g++) begin : g_tap
    dregs_seq_tap #(.W(W), .IDX(g)) u_tap (
      .wr_vld (vld_pipe[lat_pamac]),
      .wr_tap (tap_pipe[lat_pamac]),
      .rotate (is_rot),
      .clear  (is_clr),
      .en     (DRegs_en[g]),
      .clr    (DRegs_clr[g]),
      .in_sel (DRegs_in_sel[g])
    );
  end
endmodule

// File: tb/tb_dregs_seq.sv
// Directed bench for dregs_seq: three parameter corners, clear/reset behaviour
// and a bank + PAMAC scoreboard over back-to-back sweeps.

module tb_dregs_seq;
  logic clk = 1'b0;
  logic rst, start, clr_req;

  logic       busy5, done5, rd5;
  logic [2:0] tap5;
  logic [4:0] en5, clr5, sel5;

  logic        busy11, done11, rd11;
  logic [3:0]  tap11;
  logic [10:0] en11, clr11, sel11;

  logic       busy7, done7, rd7;
  logic [2:0] tap7;
  logic [6:0] en7, clr7, sel7;

  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;

  logic bank_load = 1'b0;
  int   bank [5];
  int   p1, p2;

  always #5 clk = ~clk;

  dregs_seq #(.nb_taps(5), .lat_pamac(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .clr_req(clr_req),
    .busy(busy5), .done(done5), .rd_valid(rd5), .current_tap_DRegs(tap5),
    .DRegs_en(en5), .DRegs_clr(clr5), .DRegs_in_sel(sel5));

  dregs_seq #(.nb_taps(11), .lat_pamac(4)) u_d11 (
    .clk(clk), .rst(rst), .start(start), .clr_req(clr_req),
    .busy(busy11), .done(done11), .rd_valid(rd11), .current_tap_DRegs(tap11),
    .DRegs_en(en11), .DRegs_clr(clr11), .DRegs_in_sel(sel11));

  dregs_seq #(.nb_taps(7), .lat_pamac(1)) u_d7 (
    .clk(clk), .rst(rst), .start(start), .clr_req(clr_req),
    .busy(busy7), .done(done7), .rd_valid(rd7), .current_tap_DRegs(tap7),
    .DRegs_en(en7), .DRegs_clr(clr7), .DRegs_in_sel(sel7));

  // Bank model (ring D[i] <= D[i-1]) fed by a 2-cycle PAMAC computing read+1.
  always @(posedge clk) begin
    if (bank_load) begin
      bank[0] <= 10; bank[1] <= 20; bank[2] <= 30; bank[3] <= 40; bank[4] <= 50;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (clr5[i])     bank[i] <= 0;
        else if (en5[i]) bank[i] <= sel5[i] ? p2 : bank[(i + 4) % 5];
      end
    end
    p1 <= bank[tap5] + 1;
    p2 <= p1;
  end

  always @(negedge clk)
    if (((en5 & clr5) != 0) || ((en11 & clr11) != 0) || ((en7 & clr7) != 0)) viol++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Start sampled at edge E0; cycle c is observed #1 after edge E(c-1).
  task automatic run_sweep(input bit poke);
    int e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (poke && c == 2) begin start = 1'b1; clr_req = 1'b1; end
      if (poke && c == 8) begin start = 1'b0; clr_req = 1'b0; end
      // nb_taps=5, lat=2: writes in 3..7, rotate 8, done 9
      e = (c >= 3 && c <= 7) ? (1 << (c - 3)) : 0;
      chk($sformatf("c%0d_rd5", c),   rd5,   (c <= 5) ? 1 : 0);
      chk($sformatf("c%0d_tap5", c),  tap5,  (c <= 5) ? c - 1 : 0);
      chk($sformatf("c%0d_en5", c),   en5,   (c == 8) ? 32'h1f : e);
      chk($sformatf("c%0d_sel5", c),  sel5,  e);
      chk($sformatf("c%0d_clr5", c),  clr5,  0);
      chk($sformatf("c%0d_busy5", c), busy5, (c <= 9) ? 1 : 0);
      chk($sformatf("c%0d_done5", c), done5, (c == 9) ? 1 : 0);
      // nb_taps=11, lat=4: writes in 5..15, rotate 16, done 17
      e = (c >= 5 && c <= 15) ? (1 << (c - 5)) : 0;
      chk($sformatf("c%0d_rd11", c),   rd11,   (c <= 11) ? 1 : 0);
      chk($sformatf("c%0d_tap11", c),  tap11,  (c <= 11) ? c - 1 : 0);
      chk($sformatf("c%0d_en11", c),   en11,   (c == 16) ? 32'h7ff : e);
      chk($sformatf("c%0d_done11", c), done11, (c == 17) ? 1 : 0);
      // nb_taps=7, lat=1: writes in 2..8, rotate 9, done 10
      e = (c >= 2 && c <= 8) ? (1 << (c - 2)) : 0;
      chk($sformatf("c%0d_en7", c),   en7,   (c == 9) ? 32'h7f : e);
      chk($sformatf("c%0d_done7", c), done7, (c == 10) ? 1 : 0);
    end
  endtask

  initial begin
    int   acc;
    int   ndone;
    rst = 1'b1; start = 1'b0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy5, 0);
    chk("rst_done", done5, 0);
    chk("rst_rd",   rd5,   0);
    chk("rst_tap",  tap5,  0);
    chk("rst_en",   en5,   0);
    chk("rst_clr",  clr5,  0);
    chk("rst_sel",  sel5,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_sweep(1'b0);
    run_sweep(1'b1);

    // clr_req beats a simultaneous start
    start = 1'b1; clr_req = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr_req = 1'b0;
    chk("clr_clr5",  clr5,  32'h1f);
    chk("clr_en5",   en5,   0);
    chk("clr_busy5", busy5, 1);
    chk("clr_rd5",   rd5,   0);
    chk("clr_clr11", clr11, 32'h7ff);
    chk("clr_clr7",  clr7,  32'h7f);
    @(posedge clk); #1;
    chk("clr_idle_busy", busy5, 0);
    chk("clr_idle_clr",  clr5,  0);
    acc = 0;
    repeat (4) begin
      @(posedge clk); #1;
      acc |= {rd5, done5, busy5};
    end
    chk("clr_no_sweep", acc, 0);

    // synchronous reset in the middle of ISSUE
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy5,  0);
    chk("mid_rst_rd",   rd5,    0);
    chk("mid_rst_tap",  tap5,   0);
    chk("mid_rst_en",   en5,    0);
    chk("mid_rst_sel",  sel5,   0);
    chk("mid_rst_done", done5,  0);
    chk("mid_rst_b11",  busy11, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc = 0;
    repeat (12) begin
      @(posedge clk); #1;
      acc |= int'(en5) | int'(en11) | int'(en7) | int'(done5);
    end
    chk("post_rst_quiet", acc, 0);

    // three back-to-back sweeps against the bank + PAMAC model
    bank_load = 1'b1;
    @(posedge clk); #1;
    bank_load = 1'b0;
    start = 1'b1;
    ndone = 0;
    for (int k = 0; k < 200 && ndone < 3; k++) begin
      @(posedge clk); #1;
      if (done5) ndone++;
    end
    start = 1'b0;
    chk("b2b_done_count", ndone, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_busy", busy5, 0);
    // each sweep adds 1 to every tap then rotates by one: D[i] = init[i+2] + 3
    chk("bank0", bank[0], 33);
    chk("bank1", bank[1], 43);
    chk("bank2", bank[2], 53);
    chk("bank3", bank[3], 13);
    chk("bank4", bank[4], 23);
    chk("en_clr_never", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
